instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/proc_pkg.sv | 40 ++++
 rtl/instruction_fetch_if.sv | 30 +++
 rtl/fetch_fifo.sv | 90 +++++++++
 rtl/instruction_fetch.sv | 141 ++++++++++++++
 tb/tb_instruction_fetch.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions: address/instruction widths, the bit
// positions the decoder uses to split an instruction word, the entry type
// held by the fetch buffer, and a saturating adder for event counters.
package proc_pkg;

   localparam int IMEM_ADDR_W = 12;
   localparam int INST_W      = 32;

   // Instruction field positions (MSB/LSB inclusive)
   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 27;
   localparam int RD_MSB     = 26;
   localparam int RD_LSB     = 22;
   localparam int RS_MSB     = 21;
   localparam int RS_LSB     = 17;
   localparam int RT_MSB     = 16;
   localparam int RT_LSB     = 12;
   localparam int SHAMT_MSB  = 11;
   localparam int SHAMT_LSB  = 7;
   localparam int ALUOP_MSB  = 6;
   localparam int ALUOP_LSB  = 2;
   localparam int IMM_MSB    = 16;
   localparam int IMM_LSB    = 0;

   typedef logic [IMEM_ADDR_W-1:0] imem_addr_t;
   typedef logic [INST_W-1:0]      inst_t;

   typedef struct packed {
      inst_t      inst;
      imem_addr_t pc;
   } fetch_entry_t;

   // 32-bit add that sticks at all-ones instead of wrapping
   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel and the
// instruction hand-off to the decoder.
//   imem_req/imem_addr/imem_gnt : request channel (accepted when req & gnt)
//   imem_rvalid/imem_rdata      : in-order response channel
//   inst_valid/inst_ready       : decoder handshake, inst/inst_pc payload
// master = fetch unit, slave = memory + decoder side.
interface instruction_fetch_if;
   import proc_pkg::*;

   logic       imem_req;
   imem_addr_t imem_addr;
   logic       imem_gnt;
   logic       imem_rvalid;
   inst_t      imem_rdata;
   logic       inst_valid;
   logic       inst_ready;
   inst_t      inst;
   imem_addr_t inst_pc;

   modport master (
      output imem_req, imem_addr, inst_valid, inst, inst_pc,
      input  imem_gnt, imem_rvalid, imem_rdata, inst_ready
   );

   modport slave (
      input  imem_req, imem_addr, inst_valid, inst, inst_pc,
      output imem_gnt, imem_rvalid, imem_rdata, inst_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH-entry circular FIFO of {instruction, pc}.
//   clock, resetn : clock, async active-low reset (pointers/count only)
//   push, wdata   : write an entry
//   pop           : remove the head entry (ignored when empty)
//   flush         : discard all entries; overrides push and pop
//   rdata, empty  : head entry and empty flag
//   occupancy     : number of valid entries
module fetch_fifo
   import proc_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             push,
   input  fetch_entry_t     wdata,
   input  logic             pop,
   input  logic             flush,
   output fetch_entry_t     rdata,
   output logic             empty,
   output logic [CNT_W-1:0] occupancy
);

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full;
   logic             do_push;
   logic             do_pop;

   // DEPTH need not be a power of two, so wrap explicitly
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_W'(DEPTH));
   assign do_pop    = pop & ~empty;
   // A full buffer can still take a write when the head leaves this cycle
   assign do_push   = push & (~full | do_pop);
   assign rdata     = mem_q[rd_ptr_q];
   assign occupancy = count_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is qualified by count, so it needs no reset
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit. Issues sequential word fetches to instruction
// memory, buffers in-order responses with their addresses, and presents them
// to the decoder. A request is only issued when a buffer slot is guaranteed
// (buffered + in-flight < DEPTH). A redirect flushes the buffer, restarts
// fetch at redirect_pc and discards every response still in flight.
//   clock, resetn      : clock, async active-low reset
//   bus (master)       : imem request/response and decoder handshake
//   redirect/_pc       : taken branch/jump from execute
//   fetched_count      : decoder handshakes        (INSTRUCTION_FETCH_PERF_EN)
//   flushed_count      : discarded responses + flushed entries (same macro)
// Define INSTRUCTION_FETCH_PERF_EN to add the saturating event counters.
module instruction_fetch
   import proc_pkg::*;
#(
   parameter imem_addr_t RESET_PC = 12'd0,
   parameter int         DEPTH    = 2
) (
   input  logic                clock,
   input  logic                resetn,
   instruction_fetch_if.master bus,
   input  logic                redirect,
   input  imem_addr_t          redirect_pc
`ifdef INSTRUCTION_FETCH_PERF_EN
   ,
   output logic [31:0]         fetched_count,
   output logic [31:0]         flushed_count
`endif
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

   imem_addr_t       pc_q, pc_d;
   imem_addr_t       rsp_pc_q, rsp_pc_d;   // address of the next kept response
   logic [CNT_W-1:0] outs_q, outs_d;       // requests granted, not yet answered
   logic [CNT_W-1:0] drop_q, drop_d;       // in-flight responses to discard

   logic [CNT_W-1:0] occupancy;
   logic [CNT_W:0]   credit_sum;
   logic             grant;
   logic             rsp_dec;
   logic             discard;
   logic             push;
   logic             pop;
   logic             empty;
   fetch_entry_t     wdata;
   fetch_entry_t     head;

   assign credit_sum   = {1'b0, occupancy} + {1'b0, outs_q};
   // Gated by resetn so no request leaks out while reset is held
   assign bus.imem_req  = resetn & (credit_sum < DEPTH_L);
   assign bus.imem_addr = pc_q;
   assign grant         = bus.imem_req & bus.imem_gnt;
   assign rsp_dec       = bus.imem_rvalid & (outs_q != '0);
   // Responses landing in a redirect cycle belong to the old path as well
   assign discard       = bus.imem_rvalid & (redirect | (drop_q != '0));
   assign push          = bus.imem_rvalid & ~discard;
   assign pop           = bus.inst_ready & ~empty & ~redirect;
   assign wdata         = '{inst: bus.imem_rdata, pc: rsp_pc_q};

   assign bus.inst_valid = ~empty;
   assign bus.inst       = empty ? '0 : head.inst;
   assign bus.inst_pc    = empty ? '0 : head.pc;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock     (clock),
      .resetn    (resetn),
      .push      (push),
      .wdata     (wdata),
      .pop       (pop),
      .flush     (redirect),
      .rdata     (head),
      .empty     (empty),
      .occupancy (occupancy)
   );

   always_comb begin
      pc_d     = pc_q;
      outs_d   = outs_q;
      drop_d   = drop_q;
      rsp_pc_d = rsp_pc_q;

      if (grant) pc_d = pc_q + 12'd1;
      if (redirect) pc_d = redirect_pc;

      case ({grant, rsp_dec})
         2'b10:   outs_d = outs_q + CNT_W'(1);
         2'b01:   outs_d = outs_q - CNT_W'(1);
         default: outs_d = outs_q;
      endcase

      if (bus.imem_rvalid && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
      // Everything still in flight after this cycle is old-path traffic,
      // including a grant issued in this very cycle
      if (redirect) drop_d = outs_d;

      // Kept responses are consecutive from the last fetch target
      if (push) rsp_pc_d = rsp_pc_q + 12'd1;
      if (redirect) rsp_pc_d = redirect_pc;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pc_q     <= RESET_PC;
         rsp_pc_q <= RESET_PC;
         outs_q   <= '0;
         drop_q   <= '0;
      end else begin
         pc_q     <= pc_d;
         rsp_pc_q <= rsp_pc_d;
         outs_q   <= outs_d;
         drop_q   <= drop_d;
      end
   end

`ifdef INSTRUCTION_FETCH_PERF_EN
   logic [31:0] fetched_count_q, fetched_count_d;
   logic [31:0] flushed_count_q, flushed_count_d;
   logic [31:0] flush_inc;

   always_comb begin
      flush_inc       = (redirect ? 32'(occupancy) : 32'd0) + 32'(discard);
      fetched_count_d = sat_add32(fetched_count_q, 32'(pop));
      flushed_count_d = sat_add32(flushed_count_q, flush_inc);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         fetched_count_q <= '0;
         flushed_count_q <= '0;
      end else begin
         fetched_count_q <= fetched_count_d;
         flushed_count_q <= flushed_count_d;
      end
   end

   assign fetched_count = fetched_count_q;
   assign flushed_count = flushed_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
   import proc_pkg::*;

   localparam int         DEPTH    = 2;
   localparam imem_addr_t RESET_PC = 12'h000;

   logic       clock;
   logic       resetn;
   logic       redirect;
   imem_addr_t redirect_pc;
`ifdef INSTRUCTION_FETCH_PERF_EN
   logic [31:0] fetched_count;
   logic [31:0] flushed_count;
`endif

   instruction_fetch_if bus();

   instruction_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .bus         (bus),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
`ifdef INSTRUCTION_FETCH_PERF_EN
      ,
      .fetched_count (fetched_count),
      .flushed_count (flushed_count)
`endif
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      imem_addr_t addr;
      int         epoch;
      int         due;
   } req_t;

   typedef struct {
      inst_t      data;
      imem_addr_t pc;
   } exp_t;

   req_t       memq[$];
   exp_t       sb[$];
   imem_addr_t delivered[$];

   int         checks;
   int         errors;
   int         cyc;
   int         epoch;
   int         dut_grants;
   int         lat;
   bit         gnt_en;
   bit         rdy_en;
   bit         rand_mode;
   bit         redir_req;
   imem_addr_t redir_target;
   imem_addr_t pc_m;
   logic [31:0] exp_fetched;
   logic [31:0] exp_flushed;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic inst_t data_of(input imem_addr_t a);
      return {~a, 8'h5A, a};
   endfunction

   function automatic logic [31:0] dlv(input int i);
      return (delivered.size() > i) ? 32'(delivered[i]) : 32'hDEAD_BEEF;
   endfunction

   // One clock cycle: drive inputs, compare outputs, advance the model.
   task automatic step();
      bit   g, r, rd, rv, exp_req;
      req_t f;
      g  = rand_mode ? ($urandom_range(3) != 0) : gnt_en;
      r  = rand_mode ? ($urandom_range(3) != 0) : rdy_en;
      rd = redir_req || (rand_mode && ($urandom_range(7) == 0));
      if (rand_mode && rd && !redir_req) redir_target = 12'($urandom_range(4095));
      redir_req = 1'b0;
      rv = (memq.size() > 0) && (memq[0].due <= cyc);

      bus.imem_gnt    = g;
      bus.inst_ready  = r;
      redirect        = rd;
      redirect_pc     = redir_target;
      bus.imem_rvalid = rv;
      bus.imem_rdata  = rv ? data_of(memq[0].addr) : inst_t'($urandom);
      #1;

      exp_req = (sb.size() + memq.size()) < DEPTH;
      check("imem_req", 32'(bus.imem_req), 32'(exp_req));
      check("imem_addr", 32'(bus.imem_addr), 32'(pc_m));
      check("inst_valid", 32'(bus.inst_valid), 32'(sb.size() > 0));
      if (sb.size() > 0) begin
         check("inst", bus.inst, sb[0].data);
         check("inst_pc", 32'(bus.inst_pc), 32'(sb[0].pc));
      end
      if (bus.imem_req && g) dut_grants++;

      if (rd) begin
         exp_flushed = exp_flushed + 32'(sb.size()) + 32'(rv);
         sb.delete();
      end else if (r && sb.size() > 0) begin
         delivered.push_back(sb[0].pc);
         void'(sb.pop_front());
         exp_fetched++;
      end
      if (rv) begin
         f = memq.pop_front();
         if (!rd) begin
            if (f.epoch == epoch) sb.push_back('{data_of(f.addr), f.addr});
            else exp_flushed++;
         end
      end
      if (exp_req && g) begin
         memq.push_back('{pc_m, epoch, cyc + (rand_mode ? int'($urandom_range(3, 1)) : lat)});
         pc_m = pc_m + 12'd1;
      end
      if (rd) begin
         epoch++;
         pc_m = redir_target;
      end
      @(posedge clock);
      @(negedge clock);
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Called at a negedge; returns at the negedge where resetn is released.
   task automatic do_reset(input bit late_rv);
      resetn          = 1'b0;
      redirect        = 1'b0;
      bus.imem_gnt    = 1'b1;
      bus.inst_ready  = 1'b1;
      bus.imem_rvalid = late_rv;
      bus.imem_rdata  = 32'hBAD0_0BAD;
      #1;
      check("rst_req", 32'(bus.imem_req), 32'd0);
      check("rst_addr", 32'(bus.imem_addr), 32'(RESET_PC));
      check("rst_valid", 32'(bus.inst_valid), 32'd0);
      check("rst_inst", bus.inst, 32'd0);
      check("rst_inst_pc", 32'(bus.inst_pc), 32'd0);
`ifdef INSTRUCTION_FETCH_PERF_EN
      check("rst_fetched", fetched_count, 32'd0);
      check("rst_flushed", flushed_count, 32'd0);
`endif
      @(posedge clock);
      @(negedge clock);
      @(posedge clock);
      @(negedge clock);
      check("rst_hold_req", 32'(bus.imem_req), 32'd0);
      check("rst_hold_valid", 32'(bus.inst_valid), 32'd0);
      resetn          = 1'b1;
      bus.imem_rvalid = 1'b0;
      memq.delete();
      sb.delete();
      delivered.delete();
      pc_m        = RESET_PC;
      cyc         = 0;
      dut_grants  = 0;
      exp_fetched = '0;
      exp_flushed = '0;
   endtask

   initial begin
      checks = 0; errors = 0; epoch = 0; lat = 1;
      gnt_en = 1'b1; rdy_en = 1'b1; rand_mode = 1'b0; redir_req = 1'b0;
      redir_target = '0; pc_m = RESET_PC;
      resetn = 1'b1; redirect = 1'b0; redirect_pc = '0;
      bus.imem_gnt = 1'b0; bus.inst_ready = 1'b0;
      bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
      #2;

      // Free run, 1-cycle memory: inst_pc 0,1,2,... from cycle 2
      do_reset(1'b0);
      run(2);
      check("first_valid", 32'(bus.inst_valid), 32'd1);
      check("first_pc", 32'(bus.inst_pc), 32'(RESET_PC));
      run(8);
      for (int i = 0; i < 6; i++) check("seq_pc", dlv(i), 32'(i));

      // Decoder stalled: only DEPTH grants, head stays at pc 0
      do_reset(1'b0);
      rdy_en = 1'b0;
      run(10);
      check("stall_grants", 32'(dut_grants), 32'(DEPTH));
      check("stall_req_low", 32'(bus.imem_req), 32'd0);
      check("stall_pc", 32'(bus.inst_pc), 32'(RESET_PC));
      rdy_en = 1'b1;
      run(4);

      // Redirect with two in flight: both dropped, next is 0x040
      do_reset(1'b0);
      lat = 3;
      run(2);
      delivered.delete();
      redir_req = 1'b1; redir_target = 12'h040;
      run(12);
      check("redir_first", dlv(0), 32'h040);
      check("redir_second", dlv(1), 32'h041);

      // Address wrap
      lat = 1;
      delivered.delete();
      redir_req = 1'b1; redir_target = 12'hFFE;
      run(8);
      check("wrap0", dlv(0), 32'hFFE);
      check("wrap1", dlv(1), 32'hFFF);
      check("wrap2", dlv(2), 32'h000);
      check("wrap3", dlv(3), 32'h001);

      // Back-to-back redirects, rvalid present in both cycles
      delivered.delete();
      redir_req = 1'b1; redir_target = 12'h010;
      step();
      redir_req = 1'b1; redir_target = 12'h020;
      run(8);
      check("b2b_first", dlv(0), 32'h020);
      gnt_en = 1'b0;
      run(5);
      check("b2b_outs_zero", 32'(dut.outs_q), 32'd0);
      check("b2b_drop_zero", 32'(dut.drop_q), 32'd0);
      gnt_en = 1'b1;

      // Random traffic with random redirects and latencies
      do_reset(1'b0);
      rand_mode = 1'b1;
      run(400);
      rand_mode = 1'b0;
      run(10);
`ifdef INSTRUCTION_FETCH_PERF_EN
      check("perf_fetched", fetched_count, exp_fetched);
      check("perf_flushed", flushed_count, exp_flushed);
`endif

      // Reset pulse with one response outstanding
      do_reset(1'b0);
      lat = 3;
      gnt_en = 1'b1;
      step();
      gnt_en = 1'b0;
      step();
      do_reset(1'b1);
      lat = 1; gnt_en = 1'b1;
      run(6);
      check("restart_pc", dlv(0), 32'(RESET_PC));
      check("restart_pc1", dlv(1), 32'(RESET_PC + 12'd1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
